// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: staged reset sequencer with synchronized release; optional rst_cause output under RST_SEQ_CAUSE_EN
module rst_seq_ctrl #(
  parameter int NUMBER_OF_RSTS = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int MIN_ASSERT     = 16,
  parameter int RELEASE_GAP    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sw_rst_req,
  output logic [NUMBER_OF_RSTS-1:0] rst_out_n,
  output logic                      rst_busy,
`ifdef RST_SEQ_CAUSE_EN
  output logic                      rst_done,
  output logic [1:0]                rst_cause
`else
  output logic                      rst_done
`endif
);
  localparam int MAX_CNT = MIN_ASSERT > RELEASE_GAP ? MIN_ASSERT : RELEASE_GAP;
  localparam int CW = $clog2(MAX_CNT + 1);
  typedef enum logic [1:0] {HOLD, RELEASE, DONE} state_e;
  state_e state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt_q;
  logic [NUMBER_OF_RSTS-1:0] rst_out_n_d;
  logic sync_rst_n;
  logic sw_hit;
  assign sync_rst_n = sync_q[SYNC_STAGES-1];
  assign sw_hit = sync_rst_n && sw_rst_req;
  assign rst_out_n_d = rst_out_n | (rst_out_n << 1) | NUMBER_OF_RSTS'(1);
  // async-clear, sync-release chain shifting in ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  // hold all outputs for MIN_ASSERT, then release one index every RELEASE_GAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || sw_hit) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      rst_out_n <= '0;
      rst_busy  <= 1'b1;
      rst_done  <= 1'b0;
    end else if (sync_rst_n) begin
      case (state_q)
        HOLD:
          if (cnt_q == CW'(MIN_ASSERT - 1)) begin
            rst_out_n <= rst_out_n_d;
            cnt_q     <= '0;
            state_q   <= RELEASE;
          end else cnt_q <= cnt_q + 1'b1;
        RELEASE:
          if (&rst_out_n) begin
            state_q  <= DONE;
            rst_busy <= 1'b0;
            rst_done <= 1'b1;
          end else if (cnt_q == CW'(RELEASE_GAP - 1)) begin
            rst_out_n <= rst_out_n_d;
            cnt_q     <= '0;
          end else cnt_q <= cnt_q + 1'b1;
        default: ;
      endcase
    end
  end
`ifdef RST_SEQ_CAUSE_EN
  // sticky record of which event started the current sequence
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_cause <= 2'b01;
    else if (sw_hit) rst_cause <= 2'b10;
`endif
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed checks of release timing, async reset, glitch and software reset
module tb_rst_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n, sw, sw1;
  logic [3:0] out0;
  logic [0:0] out1;
  logic busy0, done0, busy1, done1;
  int checks = 0;
  int failures = 0;
`ifdef RST_SEQ_CAUSE_EN
  logic [1:0] cause0, cause1;
  rst_seq_ctrl u0 (.clk(clk), .rst_n(rst_n), .sw_rst_req(sw), .rst_out_n(out0),
                   .rst_busy(busy0), .rst_done(done0), .rst_cause(cause0));
  rst_seq_ctrl #(.NUMBER_OF_RSTS(1), .MIN_ASSERT(1), .SYNC_STAGES(2)) u1 (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw1), .rst_out_n(out1),
    .rst_busy(busy1), .rst_done(done1), .rst_cause(cause1));
`else
  rst_seq_ctrl u0 (.clk(clk), .rst_n(rst_n), .sw_rst_req(sw), .rst_out_n(out0),
                   .rst_busy(busy0), .rst_done(done0));
  rst_seq_ctrl #(.NUMBER_OF_RSTS(1), .MIN_ASSERT(1), .SYNC_STAGES(2)) u1 (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw1), .rst_out_n(out1),
    .rst_busy(busy1), .rst_done(done1));
`endif
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic sw_pulse();
    @(negedge clk) sw = 1'b1;
    step(1);
    sw = 1'b0;
  endtask
  task automatic full_seq(input string tag);
    step(17);
    chk({tag, "_e16_out"}, out0, 4'h0);
    chk({tag, "_e16_busy"}, busy0, 1'b1);
    step(1);
    chk({tag, "_e17_out"}, out0, 4'h1);
    step(24);
    chk({tag, "_e41_out"}, out0, 4'hf);
    chk({tag, "_e41_done"}, done0, 1'b0);
    step(1);
    chk({tag, "_e42_done"}, done0, 1'b1);
    chk({tag, "_e42_busy"}, busy0, 1'b0);
  endtask
  initial begin
    rst_n = 1'b1;
    sw = 1'b0;
    sw1 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out", out0, 4'h0);
    chk("rst_busy", busy0, 1'b1);
    chk("rst_done", done0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(2);
    chk("t1_e1_out", out0, 4'h0);
    chk("t6_e1_out1", out1, 1'b0);
    step(1);
    chk("t6_e2_out1", out1, 1'b1);
    chk("t6_e2_done1", done1, 1'b0);
    step(1);
    chk("t6_e3_done1", done1, 1'b1);
    chk("t6_e3_busy1", busy1, 1'b0);
    step(13);
    chk("t1_e16_out", out0, 4'h0);
    chk("t1_e16_busy", busy0, 1'b1);
    chk("t1_e16_done", done0, 1'b0);
    step(1);
    chk("t1_e17_out", out0, 4'h1);
    step(7);
    chk("t1_e24_out", out0, 4'h1);
    step(1);
    chk("t1_e25_out", out0, 4'h3);
    step(8);
    chk("t1_e33_out", out0, 4'h7);
    step(8);
    chk("t1_e41_out", out0, 4'hf);
    chk("t1_e41_done", done0, 1'b0);
    chk("t1_e41_busy", busy0, 1'b1);
    step(1);
    chk("t1_e42_done", done0, 1'b1);
    chk("t1_e42_busy", busy0, 1'b0);
`ifdef RST_SEQ_CAUSE_EN
    chk("t1_cause", cause0, 2'b01);
`endif
    sw_pulse();
    chk("t3_ek_out", out0, 4'h0);
    chk("t3_ek_done", done0, 1'b0);
    chk("t3_ek_busy", busy0, 1'b1);
`ifdef RST_SEQ_CAUSE_EN
    chk("t3_cause", cause0, 2'b10);
`endif
    step(15);
    chk("t3_k15_out", out0, 4'h0);
    step(1);
    chk("t3_k16_out", out0, 4'h1);
    step(24);
    chk("t3_k40_out", out0, 4'hf);
    chk("t3_k40_done", done0, 1'b0);
    step(1);
    chk("t3_k41_done", done0, 1'b1);
    sw_pulse();
    step(10);
    sw_pulse();
    step(5);
    chk("t4_m5_out", out0, 4'h0);
    step(10);
    chk("t4_m15_out", out0, 4'h0);
    step(1);
    chk("t4_m16_out", out0, 4'h1);
    step(25);
    chk("t4_m41_out", out0, 4'hf);
    chk("t4_m41_done", done0, 1'b1);
    @(negedge clk) sw = 1'b1;
    step(20);
    chk("hold_out", out0, 4'h0);
    chk("hold_busy", busy0, 1'b1);
    @(negedge clk) sw = 1'b0;
    step(15);
    chk("hold_k15_out", out0, 4'h0);
    step(1);
    chk("hold_k16_out", out0, 4'h1);
    step(25);
    chk("hold_k41_done", done0, 1'b1);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step(31);
    chk("t2_e30_out", out0, 4'h3);
    rst_n = 1'b0;
    #1;
    chk("t2_async_out", out0, 4'h0);
    chk("t2_async_busy", busy0, 1'b1);
    chk("t2_async_done", done0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    full_seq("t2");
    rst_n = 1'b0;
    #1;
    chk("t5_glitch_out", out0, 4'h0);
    chk("t5_glitch_done", done0, 1'b0);
    #2 rst_n = 1'b1;
    full_seq("t5");
`ifdef RST_SEQ_CAUSE_EN
    chk("t5_cause", cause0, 2'b01);
`endif
    @(negedge clk) sw1 = 1'b1;
    step(1);
    sw1 = 1'b0;
    chk("t6_sw_out1", out1, 1'b0);
    chk("t6_sw_done1", done1, 1'b0);
`ifdef RST_SEQ_CAUSE_EN
    chk("t6_cause1", cause1, 2'b10);
`endif
    step(1);
    chk("t6_sw_rel_out1", out1, 1'b1);
    chk("t6_sw_rel_done1", done1, 1'b0);
    step(1);
    chk("t6_sw_done1_hi", done1, 1'b1);
    chk("t6_u0_untouched", done0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
